// File: rtl/gost_round_seq.sv
// Sequencer for the GOST 28147-89 round unit: 32 keyed iterations, recirculation, final half-swap.
// Optional GOST_DECRYPT_EN adds an idecrypt port that selects the decryption key order.
module gost_round_seq #(
    parameter int unsigned NROUNDS = 32
) (
    input  logic         iclk,
    input  logic         irst,
    input  logic         istart,
    input  logic [63:0]  iblock,
    input  logic [255:0] ikey,
`ifdef GOST_DECRYPT_EN
    input  logic         idecrypt,
`endif
    output logic [63:0]  oblock,
    output logic         odone,
    output logic         obusy,
    output logic         oround_start,
    output logic [63:0]  oround_block,
    output logic [31:0]  oround_key,
    input  logic [63:0]  iround_block,
    input  logic         iround_done
);

    localparam int unsigned BLK_W = 64;
    localparam int unsigned KEY_W = 256;
    localparam int unsigned SK_W  = 32;
    localparam int unsigned CNT_W = 5;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             r_state, w_state_nxt;
    logic [CNT_W-1:0]   r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [KEY_W-1:0]   r_key, w_key_nxt;
    logic               r_dec, w_dec_nxt, w_dec_in;
    logic [BLK_W-1:0]   r_rblk, w_rblk_nxt;
    logic [SK_W-1:0]    r_sub, w_sub_nxt;
    logic               r_start, w_start_nxt;
    logic               r_busy, w_busy_nxt;
    logic               r_done, w_done_nxt;
    logic [BLK_W-1:0]   r_oblock, w_oblock_nxt;

`ifdef GOST_DECRYPT_EN
    assign w_dec_in = idecrypt;
`else
    assign w_dec_in = 1'b0;
`endif

    assign w_cnt_inc = r_cnt + CNT_W'(1);

    // Encryption reverses the key order for the last 8 rounds; decryption for all but the first 8.
    function automatic logic [SK_W-1:0] f_subkey(input logic [KEY_W-1:0] key,
                                                 input logic [CNT_W-1:0] rnd,
                                                 input logic             dec);
        logic       tail;
        logic [2:0] idx;
        tail = dec ? (rnd >= CNT_W'(8)) : (rnd >= CNT_W'(NROUNDS - 8));
        idx  = tail ? ~rnd[2:0] : rnd[2:0];
        return key[{idx, 5'b00000} +: SK_W];
    endfunction

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_key_nxt    = r_key;
        w_dec_nxt    = r_dec;
        w_rblk_nxt   = r_rblk;
        w_sub_nxt    = r_sub;
        w_start_nxt  = 1'b0;
        w_busy_nxt   = r_busy;
        w_done_nxt   = 1'b0;
        w_oblock_nxt = r_oblock;
        case (r_state)
            S_IDLE: begin
                if (istart) begin
                    w_key_nxt   = ikey;
                    w_dec_nxt   = w_dec_in;
                    w_rblk_nxt  = iblock;
                    w_cnt_nxt   = '0;
                    w_busy_nxt  = 1'b1;
                    w_sub_nxt   = f_subkey(ikey, CNT_W'(0), w_dec_in);
                    w_start_nxt = 1'b1;
                    w_state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (iround_done) begin
                    w_rblk_nxt = iround_block;
                    if (r_cnt == CNT_W'(NROUNDS - 1)) begin
                        // Last round must be unswapped: undo the round unit's half-swap.
                        w_oblock_nxt = {iround_block[31:0], iround_block[63:32]};
                        w_done_nxt   = 1'b1;
                        w_state_nxt  = S_DONE;
                    end else begin
                        w_cnt_nxt   = w_cnt_inc;
                        w_sub_nxt   = f_subkey(r_key, w_cnt_inc, r_dec);
                        w_start_nxt = 1'b1;
                        w_state_nxt = S_ISSUE;
                    end
                end
            end
            S_DONE: begin
                w_busy_nxt  = 1'b0;
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_key    <= '0;
            r_dec    <= 1'b0;
            r_rblk   <= '0;
            r_sub    <= '0;
            r_start  <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_oblock <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_key    <= w_key_nxt;
            r_dec    <= w_dec_nxt;
            r_rblk   <= w_rblk_nxt;
            r_sub    <= w_sub_nxt;
            r_start  <= w_start_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;
            r_oblock <= w_oblock_nxt;
        end
    end

    assign oblock       = r_oblock;
    assign odone        = r_done;
    assign obusy        = r_busy;
    assign oround_start = r_start;
    assign oround_block = r_rblk;
    assign oround_key   = r_sub;

endmodule

// File: tb/tb_gost_round_seq.sv
// Directed bench for gost_round_seq with a behavioural round unit of fixed latency.
module tb_gost_round_seq;

    localparam int unsigned NR  = 32;
    localparam int unsigned LAT = 3;

    logic         iclk;
    logic         irst;
    logic         istart;
    logic [63:0]  iblock;
    logic [255:0] ikey;
`ifdef GOST_DECRYPT_EN
    logic         idecrypt;
`endif
    logic [63:0]  oblock;
    logic         odone;
    logic         obusy;
    logic         oround_start;
    logic [63:0]  oround_block;
    logic [31:0]  oround_key;
    logic [63:0]  iround_block;
    logic         iround_done;

    logic [63:0]  m_blk, m_res, inj_blk;
    logic         m_done, inj_done;
    int           m_cnt;
    int           m_mode;
    logic [31:0]  keyq[$];

    int n_total = 0;
    int n_bad   = 0;

    gost_round_seq #(.NROUNDS(NR)) dut (
        .iclk         (iclk),
        .irst         (irst),
        .istart       (istart),
        .iblock       (iblock),
        .ikey         (ikey),
`ifdef GOST_DECRYPT_EN
        .idecrypt     (idecrypt),
`endif
        .oblock       (oblock),
        .odone        (odone),
        .obusy        (obusy),
        .oround_start (oround_start),
        .oround_block (oround_block),
        .oround_key   (oround_key),
        .iround_block (iround_block),
        .iround_done  (iround_done)
    );

    initial iclk = 1'b0;
    always #5 iclk = ~iclk;

    // Round unit model: mode 0 echoes the block, mode 1 is a Feistel round with F = key.
    always @(posedge iclk or negedge irst) begin
        if (!irst) begin
            m_done <= 1'b0;
            m_cnt  <= 0;
            m_blk  <= '0;
            m_res  <= '0;
        end else begin
            m_done <= 1'b0;
            if (oround_start) begin
                keyq.push_back(oround_key);
                m_cnt <= LAT - 1;
                m_res <= (m_mode == 1) ? {oround_block[31:0], oround_block[63:32] ^ oround_key}
                                       : oround_block;
            end else if (m_cnt > 0) begin
                m_cnt <= m_cnt - 1;
                if (m_cnt == 1) begin
                    m_done <= 1'b1;
                    m_blk  <= m_res;
                end
            end
        end
    end

    assign iround_done  = m_done | inj_done;
    assign iround_block = inj_done ? inj_blk : m_blk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] ref_enc(input logic [63:0] blk, input logic [255:0] key,
                                            input logic [127:0] ord);
        logic [31:0] h, l, t, k;
        logic [3:0]  j;
        h = blk[63:32];
        l = blk[31:0];
        for (int r = 0; r < int'(NR); r++) begin
            j = ord[127 - 4*r -: 4];
            k = key[32*j +: 32];
            t = l;
            l = h ^ k;
            h = t;
        end
        return {l, h};
    endfunction

    task automatic check_keys(input logic [255:0] key, input logic [127:0] ord);
        logic [3:0]  j;
        logic [31:0] e, g;
        chk("pulses", 64'(keyq.size()), 64'(NR));
        for (int r = 0; r < int'(NR); r++) begin
            j = ord[127 - 4*r -: 4];
            e = key[32*j +: 32];
            g = (r < keyq.size()) ? keyq[r] : ~e;
            chk("keyord", 64'(g), 64'(e));
        end
    endtask

    task automatic run_op(input logic [63:0] blk, input logic [255:0] key, input logic dec,
                          input logic noisy, output logic [63:0] res);
        int   lat;
        logic busy_ok, seen;
        keyq.delete();
        @(negedge iclk);
        istart = 1'b1;
        iblock = blk;
        ikey   = key;
`ifdef GOST_DECRYPT_EN
        idecrypt = dec;
`endif
        @(negedge iclk);
        istart = 1'b0;
        iblock = ~blk;
        ikey   = ~key;
`ifdef GOST_DECRYPT_EN
        idecrypt = ~dec;
`endif
        lat = 0;
        busy_ok = 1'b1;
        seen = 1'b0;
        for (int c = 1; c < 2000 && !seen; c++) begin
            if (!obusy) busy_ok = 1'b0;
            if (odone) begin
                lat  = c;
                seen = 1'b1;
            end else begin
                istart   = noisy && (c == 21 || c == 81);
                inj_done = noisy && (c == 9 || c == 45);
                @(negedge iclk);
            end
        end
        istart   = 1'b0;
        inj_done = 1'b0;
        chk("done_seen", 64'(seen), 64'(1));
        chk("latency", 64'(lat), 64'(NR * (LAT + 1) + 1));
        chk("busy_high", 64'(busy_ok), 64'(1));
        res = oblock;
        @(negedge iclk);
        chk("done_pulse", 64'(odone), 64'(0));
        chk("busy_low", 64'(obusy), 64'(0));
        chk("held", oblock, res);
        if (dec) res = oblock;
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_oblock"}, oblock, 64'h0);
        chk({tag, "_odone"}, 64'(odone), 64'h0);
        chk({tag, "_obusy"}, 64'(obusy), 64'h0);
        chk({tag, "_rstart"}, 64'(oround_start), 64'h0);
        chk({tag, "_rblock"}, oround_block, 64'h0);
        chk({tag, "_rkey"}, 64'(oround_key), 64'h0);
    endtask

    initial begin
        logic [127:0] ord_enc, ord_dec;
        logic [255:0] ka, kb, k2;
        logic [63:0]  pt, res, ct2, exp2;
        int           extra;

        ord_enc = 128'h01234567_01234567_01234567_76543210;
        ord_dec = 128'h01234567_76543210_76543210_76543210;
        ka = 256'h00000007_00000006_00000005_00000004_00000003_00000002_00000001_00000000;
        kb = 256'h77777777_66666666_55555555_44444444_33333333_22222222_11111111_00000000;
        k2 = 256'h01234567_89ABCDEF_FEDCBA98_76543210_DEADBEEF_CAFEF00D_13579BDF_2468ACE0;
        pt = 64'h0123456789ABCDEF;

        irst     = 1'b0;
        istart   = 1'b0;
        iblock   = '0;
        ikey     = '0;
`ifdef GOST_DECRYPT_EN
        idecrypt = 1'b0;
`endif
        inj_done = 1'b0;
        inj_blk  = 64'hBADC0FFEE0DDF00D;
        m_mode   = 0;

        repeat (2) @(negedge iclk);
        check_zero_outputs("reset");
        irst = 1'b1;

        // Key order with an echoing round unit: result is just the swapped input.
        m_mode = 0;
        run_op(pt, ka, 1'b0, 1'b0, res);
        check_keys(ka, ord_enc);
        chk("echo_result", res, 64'h89ABCDEF01234567);

        // Data path: with Kj = 0x11111111*j every key cancels out in both halves.
        m_mode = 1;
        run_op(pt, kb, 1'b0, 1'b0, res);
        chk("dp_kb", res, 64'h89ABCDEF01234567);

        exp2 = ref_enc(pt, k2, ord_enc);
        run_op(pt, k2, 1'b0, 1'b0, ct2);
        chk("dp_k2", ct2, exp2);
        check_keys(k2, ord_enc);

        // Stray istart and iround_done during the run must not disturb anything.
        run_op(pt, k2, 1'b0, 1'b1, res);
        chk("noisy_result", res, exp2);
        check_keys(k2, ord_enc);

        // Mid-run reset around round 12.
        @(negedge iclk);
        istart = 1'b1;
        iblock = pt;
        ikey   = k2;
        @(negedge iclk);
        istart = 1'b0;
        repeat (48) @(negedge iclk);
        irst = 1'b0;
        #1;
        check_zero_outputs("midrst");
        repeat (2) @(negedge iclk);
        irst = 1'b1;
        extra = 0;
        repeat (150) begin
            @(negedge iclk);
            if (odone) extra++;
        end
        chk("no_done_after_rst", 64'(extra), 64'(0));
        run_op(pt, k2, 1'b0, 1'b0, res);
        chk("after_rst", res, exp2);

`ifdef GOST_DECRYPT_EN
        m_mode = 0;
        run_op(pt, ka, 1'b1, 1'b0, res);
        check_keys(ka, ord_dec);
        m_mode = 1;
        run_op(64'h89ABCDEF01234567, kb, 1'b1, 1'b0, res);
        chk("dec_kb", res, pt);
        run_op(ct2, k2, 1'b1, 1'b0, res);
        chk("dec_k2", res, pt);
`endif

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
